// File: rtl/ram_dma_pkg.sv
// Shared types and default widths for the RAM block-copy engine and its RAM.
package ram_dma_pkg;

    localparam int ADR_W  = 16;
    localparam int DATA_W = 64;
    localparam int LEN_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/ram_dma.sv
// Memory-to-memory block copy master on the single-port data RAM: one read and one write cycle per word.
// Optional running checksum of copied words is enabled with RAM_DMA_CHECKSUM_EN.
module ram_dma #(
    parameter int ADR_W  = ram_dma_pkg::ADR_W,
    parameter int DATA_W = ram_dma_pkg::DATA_W,
    parameter int LEN_W  = ram_dma_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADR_W-1:0]  srcAdr,
    input  logic [ADR_W-1:0]  dstAdr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [ADR_W-1:0]  adr,
    output logic [DATA_W-1:0] writeData,
    output logic              writeEn,
`ifdef RAM_DMA_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    input  logic [DATA_W-1:0] readData
);
    import ram_dma_pkg::*;

    state_t            state_q, state_d;
    logic [ADR_W-1:0]  src_q, src_d;
    logic [ADR_W-1:0]  dst_q, dst_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [LEN_W-1:0]  idx_inc;
    logic [ADR_W-1:0]  idx_a;

    assign idx_inc   = idx_q + LEN_W'(1);
    assign idx_a     = ADR_W'(idx_q);
    assign writeData = buf_q;

`ifdef RAM_DMA_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
    assign checksum = csum_q;
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        adr     = adr_q;
        writeEn = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
`ifdef RAM_DMA_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = srcAdr;
                    dst_d   = dstAdr;
                    len_d   = len;
                    idx_d   = '0;
                    state_d = (len == '0) ? DONE : READ;
`ifdef RAM_DMA_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            READ: begin
                adr     = src_q + idx_a;
                busy    = 1'b1;
                buf_d   = readData;
                state_d = WRITE;
`ifdef RAM_DMA_CHECKSUM_EN
                csum_d  = csum_q + readData;
`endif
            end
            WRITE: begin
                adr     = dst_q + idx_a;
                busy    = 1'b1;
                writeEn = 1'b1;
                idx_d   = idx_inc;
                // idx never exceeds len-1 here, so idx+1 cannot overflow LEN_W
                state_d = (idx_inc == len_q) ? DONE : READ;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // adr keeps its last driven value through IDLE and DONE
        adr_d = adr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            adr_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            adr_q   <= adr_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

`ifdef RAM_DMA_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) csum_q <= '0;
        else     csum_q <= csum_d;
    end
`endif

endmodule

// File: tb/tb_ram_dma.sv
// Scoreboard bench for ram_dma: a tb-side RAM, an ascending-copy reference model and a decoupled monitor.
module tb_ram_dma;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] srcAdr, dstAdr;
    logic [LW-1:0] len;
    logic          busy, done, writeEn;
    logic [AW-1:0] adr;
    logic [DW-1:0] writeData, readData;
`ifdef RAM_DMA_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    ram_dma dut (
        .clk(clk), .rst(rst), .start(start),
        .srcAdr(srcAdr), .dstAdr(dstAdr), .len(len),
        .busy(busy), .done(done), .adr(adr),
        .writeData(writeData), .writeEn(writeEn),
`ifdef RAM_DMA_CHECKSUM_EN
        .checksum(checksum),
`endif
        .readData(readData)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem     [0:65535];
    logic [DW-1:0] ref_mem [0:65535];
    assign readData = mem[adr];

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           wq[$];
    logic [AW-1:0] rq[$];
    int            dq[$];
    int            errs = 0, checks = 0;
    int            we_total = 0, busy_total = 0;
    logic [DW-1:0] csum_exp;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem[a]     = d;
        ref_mem[a] = d;
    endtask

    // RAM commits mid-cycle of a writeEn cycle; the monitor owns that write.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (busy) busy_total++;
                if (writeEn) begin
                    we_total++;
                    if (wq.size() == 0) chk("unexpected_write", 1, 0);
                    else begin
                        wr_t w = wq.pop_front();
                        chk("wr_adr", 64'(adr), 64'(w.a));
                        chk("wr_data", writeData, w.d);
                    end
                    mem[adr] = writeData;
                end else if (busy) begin
                    if (rq.size() == 0) chk("unexpected_read", 1, 0);
                    else chk("rd_adr", 64'(adr), 64'(rq.pop_front()));
                end
                if (done) begin
                    if (dq.size() == 0) chk("unexpected_done", 1, 0);
                    else chk("done_cycle", 64'(cyc), 64'(dq.pop_front()));
                end
            end
        end
    endtask

    // Model: ascending word-by-word copy, first `lim` words only.
    task automatic model(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n, input int lim);
        csum_exp = '0;
        for (int i = 0; i < n && i < lim; i++) begin
            logic [AW-1:0] as, ad;
            logic [DW-1:0] v;
            as = AW'(int'(s) + i);
            ad = AW'(int'(d) + i);
            v  = ref_mem[as];
            csum_exp += v;
            rq.push_back(as);
            wq.push_back('{a: ad, d: v});
            ref_mem[ad] = v;
        end
    endtask

    task automatic issue(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n, output int e);
        @(negedge clk);
        srcAdr = s; dstAdr = d; len = LW'(n); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = cyc;
        srcAdr = AW'($urandom); dstAdr = AW'($urandom); len = LW'($urandom);
    endtask

    task automatic run(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n, input bit mid_start);
        int e, we0, b0;
        bit got;
        model(s, d, n, n);
        we0 = we_total; b0 = busy_total;
        issue(s, d, n, e);
        dq.push_back(e + 2 * n);
        if (mid_start && n >= 2) begin
            @(negedge clk);
            srcAdr = AW'(int'(s) + 1); dstAdr = AW'(int'(d) + 7); len = 5; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        got = 1'b0;
        for (int t = 0; t < 2 * n + 10; t++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
        end
        chk("done_seen", 64'(got), 1);
        chk("we_cycles", 64'(we_total - we0), 64'(n));
        chk("busy_cycles", 64'(busy_total - b0), 64'(2 * n));
`ifdef RAM_DMA_CHECKSUM_EN
        chk("checksum", checksum, csum_exp);
`endif
        @(negedge clk);
        chk("done_pulse_1cyc", 64'({done, busy}), 0);
        chk("queues_drained", 64'(wq.size() + rq.size() + dq.size()), 0);
        for (int i = -1; i <= n; i++) begin
            logic [AW-1:0] a;
            a = AW'(int'(d) + i);
            chk("mem_region", mem[a], ref_mem[a]);
        end
    endtask

    initial begin
        int e;
        rst = 1'b1; start = 1'b0; srcAdr = '0; dstAdr = '0; len = '0;
        for (int i = 0; i < 65536; i++) poke(AW'(i), {$urandom, $urandom});
        fork monitor(); join_none
        #12;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_adr", 64'(adr), 0);
        chk("rst_wdata", writeData, 0);
        chk("rst_we", 64'(writeEn), 0);
`ifdef RAM_DMA_CHECKSUM_EN
        chk("rst_checksum", checksum, 0);
`endif
        @(negedge clk); rst = 1'b0;

        poke(0, 11); poke(1, 22); poke(2, 33); poke(3, 44);
        run(0, 100, 4, 0);
        chk("basic_100", mem[100], 11); chk("basic_101", mem[101], 22);
        chk("basic_102", mem[102], 33); chk("basic_103", mem[103], 44);

        run(5, 200, 0, 0);

        poke(65534, 7); poke(65535, 8); poke(0, 9);
        run(65534, 10, 3, 0);
        chk("wrap_10", mem[10], 7); chk("wrap_11", mem[11], 8); chk("wrap_12", mem[12], 9);

        poke(0, 1); poke(1, 2); poke(2, 3);
        run(0, 1, 3, 0);
        for (int i = 0; i < 4; i++) chk("overlap", mem[i], 1);

        // Abort during the second WRITE: only dst+0 and dst+1 land.
        model(500, 600, 4, 2);
        issue(500, 600, 4, e);
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_we", 64'(writeEn), 0);
        chk("abort_busy", 64'(busy), 0);
        chk("abort_adr", 64'(adr), 0);
`ifdef RAM_DMA_CHECKSUM_EN
        chk("abort_checksum", checksum, 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("abort_q", 64'(wq.size() + rq.size()), 0);
        for (int i = 0; i < 4; i++) chk("abort_mem", mem[600 + i], ref_mem[600 + i]);
        chk("abort_untouched", mem[602], ref_mem[502 + 100]);
        run(500, 700, 4, 0);

        poke(300, 5); poke(301, 6); poke(302, 7);
        run(300, 400, 3, 1);
`ifdef RAM_DMA_CHECKSUM_EN
        chk("checksum_18", checksum, 18);
`endif
        chk("ign_400", mem[400], 5); chk("ign_402", mem[402], 7);

        run(50, 50, 5, 0);

        for (int k = 0; k < 12; k++)
            run(AW'($urandom), AW'($urandom), int'($urandom_range(0, 16)), bit'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
